// File: rtl/msrv32_trap_ctrl.sv
// msrv32_trap_ctrl: machine-mode trap / return sequencer for the msrv32 core.
// Decodes ECALL/EBREAK/MRET, prioritises interrupts over exceptions, and
// drives PC-source select, flush, CSR update strobes and instret increment.
// Optional WFI support: define MSRV32_TRAP_CTRL_WFI_EN to add a WAIT_IRQ
// state; without it WFI retires as a plain NOP.
module msrv32_trap_ctrl #(
    parameter int RESET_CYCLES = 2
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [4:0] opcode_6_to_2_in,
    input  logic [2:0] funct3_in,
    input  logic [6:0] funct7_in,
    input  logic [4:0] rs1_addr_in,
    input  logic [4:0] rs2_addr_in,
    input  logic [4:0] rd_addr_in,
    input  logic       illegal_instr_in,
    input  logic       misaligned_load_in,
    input  logic       misaligned_store_in,
    input  logic       misaligned_instr_in,
    input  logic       mie_in,
    input  logic       meie_in,
    input  logic       mtie_in,
    input  logic       msie_in,
    input  logic       meip_in,
    input  logic       mtip_in,
    input  logic       msip_in,
    output logic       trap_taken_out,
    output logic       i_or_e_out,
    output logic [3:0] cause_out,
    output logic       set_cause_out,
    output logic       set_epc_out,
    output logic       mie_clear_out,
    output logic       mie_set_out,
    output logic       instret_inc_out,
    output logic [1:0] pc_src_out,
    output logic       flush_out
);

    localparam logic [3:0] RST_LOAD = 4'(RESET_CYCLES);

    typedef enum logic [2:0] {
        RESET       = 3'd0,
        OPERATING   = 3'd1,
        TRAP_TAKEN  = 3'd2,
`ifdef MSRV32_TRAP_CTRL_WFI_EN
        TRAP_RETURN = 3'd3,
        WAIT_IRQ    = 3'd4
`else
        TRAP_RETURN = 3'd3
`endif
    } state_e;

    state_e     r_state;
    state_e     w_next;
    logic [3:0] r_rst_cnt;
    logic [3:0] w_cause;

    // SYSTEM-instruction decode; all three forms need rs1 = rd = 0
    logic w_is_sys, w_regs_zero, w_ecall, w_ebreak, w_mret;
    assign w_is_sys    = (opcode_6_to_2_in == 5'b11100) && (funct3_in == 3'b000);
    assign w_regs_zero = (rs1_addr_in == 5'd0) && (rd_addr_in == 5'd0);
    assign w_ecall     = w_is_sys && w_regs_zero && (funct7_in == 7'd0) && (rs2_addr_in == 5'd0);
    assign w_ebreak    = w_is_sys && w_regs_zero && (funct7_in == 7'd0) && (rs2_addr_in == 5'd1);
    assign w_mret      = w_is_sys && w_regs_zero && (funct7_in == 7'b0011000) && (rs2_addr_in == 5'b00010);
`ifdef MSRV32_TRAP_CTRL_WFI_EN
    logic w_wfi;
    assign w_wfi       = w_is_sys && w_regs_zero && (funct7_in == 7'b0001000) && (rs2_addr_in == 5'b00101);
`endif

    // Interrupt pending ignores mstatus.MIE (used to wake from WFI); irq does not
    logic w_irq_pend, w_irq, w_exc, w_trap;
    assign w_irq_pend = (meie_in & meip_in) | (msie_in & msip_in) | (mtie_in & mtip_in);
    assign w_irq      = mie_in & w_irq_pend;
    assign w_exc      = misaligned_instr_in | illegal_instr_in | w_ecall | w_ebreak
                      | misaligned_store_in | misaligned_load_in;
    assign w_trap     = w_irq | w_exc;

    // Cause encoding: interrupts outrank exceptions, fixed order within each group
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned and a latch is never inferred.
        w_cause = 4'd0;
        if (w_irq) begin
            if (meie_in & meip_in)      w_cause = 4'd11;
            else if (msie_in & msip_in) w_cause = 4'd3;
            else                        w_cause = 4'd7;
        end else if (misaligned_instr_in) w_cause = 4'd0;
        else if (illegal_instr_in)        w_cause = 4'd2;
        else if (w_ecall)                 w_cause = 4'd11;
        else if (w_ebreak)                w_cause = 4'd3;
        else if (misaligned_store_in)     w_cause = 4'd6;
        else if (misaligned_load_in)      w_cause = 4'd4;
    end

    // State register and reset-hold counter
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst_in) begin
            r_state   <= RESET;
            r_rst_cnt <= RST_LOAD;
        end else begin
            r_state <= w_next;
            if (r_state == RESET && r_rst_cnt > 4'd1)
                r_rst_cnt <= r_rst_cnt - 4'd1;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            RESET:       if (r_rst_cnt <= 4'd1) w_next = OPERATING;
            OPERATING: begin
                if (w_trap)      w_next = TRAP_TAKEN;
                else if (w_mret) w_next = TRAP_RETURN;
`ifdef MSRV32_TRAP_CTRL_WFI_EN
                else if (w_wfi)  w_next = WAIT_IRQ;
`endif
            end
            TRAP_TAKEN:  w_next = OPERATING;
            TRAP_RETURN: w_next = OPERATING;
`ifdef MSRV32_TRAP_CTRL_WFI_EN
            WAIT_IRQ:    if (w_irq_pend) w_next = OPERATING;
`endif
            default:     w_next = RESET;
        endcase
    end

    // Output decode; while reset is asserted the reset outputs apply and no strobe fires
    always_comb begin
        trap_taken_out  = 1'b0;
        i_or_e_out      = 1'b0;
        cause_out       = 4'd0;
        set_cause_out   = 1'b0;
        set_epc_out     = 1'b0;
        mie_clear_out   = 1'b0;
        mie_set_out     = 1'b0;
        instret_inc_out = 1'b0;
        pc_src_out      = 2'b01;
        flush_out       = 1'b1;
        if (rst_in || r_state == RESET) begin
            pc_src_out = 2'b00;
        end else if (r_state == OPERATING) begin
            if (w_trap) begin
                trap_taken_out = 1'b1;
                i_or_e_out     = w_irq;
                cause_out      = w_cause;
                set_cause_out  = 1'b1;
                set_epc_out    = 1'b1;
                mie_clear_out  = 1'b1;
                pc_src_out     = 2'b11;
            end else if (w_mret) begin
                mie_set_out     = 1'b1;
                instret_inc_out = 1'b1;
                pc_src_out      = 2'b10;
            end else begin
                instret_inc_out = 1'b1;
                flush_out       = 1'b0;
            end
        end
    end

endmodule

// File: doc/msrv32_trap_ctrl.md
Name: msrv32_trap_ctrl

Overview:
Machine-mode trap and return sequencer for the msrv32 two-stage core. It sits directly downstream of the decode stage and consumes its exception flags (illegal instruction, misaligned load/store) plus interrupt requests and SYSTEM-instruction fields. It produces `trap_taken_out`, which is fed back to the decoder to suppress memory writes. It also drives PC-source selection, pipeline flush, CSR update strobes and instret increment.

Parameters:
- `RESET_CYCLES`, default 2: cycles spent in `RESET` after `rst_in` deasserts before fetch proceeds (legal range 1..15).

Ports:
- `clk_in` | input | 1 | core clock.
- `rst_in` | input | 1 | synchronous, active-high reset.
- `opcode_6_to_2_in` | input | 5 | opcode bits [6:2] of the instruction in decode.
- `funct3_in` | input | 3 | instruction funct3.
- `funct7_in` | input | 7 | instruction bits [31:25].
- `rs1_addr_in`, `rs2_addr_in`, `rd_addr_in` | input | 5 each | register fields.
- `illegal_instr_in` | input | 1 | from decoder.
- `misaligned_load_in`, `misaligned_store_in` | input | 1 each | from decoder.
- `misaligned_instr_in` | input | 1 | branch/jump target not 4-byte aligned.
- `mie_in` | input | 1 | mstatus.MIE.
- `meie_in`, `mtie_in`, `msie_in` | input | 1 each | mie-register enables.
- `meip_in`, `mtip_in`, `msip_in` | input | 1 each | pending interrupt lines.
- `trap_taken_out` | output | 1 | trap accepted this cycle (combinational).
- `i_or_e_out` | output | 1 | 1 = interrupt, 0 = exception.
- `cause_out` | output | 4 | mcause code.
- `set_cause_out`, `set_epc_out` | output | 1 each | CSR write strobes.
- `mie_clear_out`, `mie_set_out` | output | 1 each | mstatus.MIE / MPIE update strobes.
- `instret_inc_out` | output | 1 | instruction retired.
- `pc_src_out` | output | 2 | 00 boot, 01 next PC, 10 mepc, 11 trap vector.
- `flush_out` | output | 1 | kill the instruction in the fetch/decode register.

Behaviour:
- **State register** with states `RESET`, `OPERATING`, `TRAP_TAKEN`, `TRAP_RETURN` (`WAIT_IRQ` only under the optional feature). It has a 4-bit reset counter.
- **Reset:** `rst_in` high in any state forces `RESET` next cycle and reloads the counter to `RESET_CYCLES`. This includes reset mid-trap. A trap in flight is abandoned; no strobes fire.
- **RESET outputs:** `pc_src_out`=00, `flush_out`=1, `cause_out`=0. All other outputs are 0.
- **RESET exit:** the counter decrements each cycle with `rst_in` low. The FSM moves to `OPERATING` when the counter reaches 1.
- **SYSTEM decode:** decoded only when `opcode_6_to_2_in`=11100 and `funct3_in`=000.
  - ECALL: `funct7_in`=0, `rs2_addr_in`=0.
  - EBREAK: `funct7_in`=0, `rs2_addr_in`=1.
  - MRET: `funct7_in`=0011000, `rs2_addr_in`=00010.
  - In all three cases `rs1_addr_in` and `rd_addr_in` must be 0. Otherwise the instruction is none of these.
- **Interrupt request:** `irq` = `mie_in` & ((`meie_in`&`meip_in`) | (`msie_in`&`msip_in`) | (`mtie_in`&`mtip_in`)).
  - Priority: MEI (cause 11) > MSI (3) > MTI (7).
- **Exception priority:** misaligned instr (0) > illegal (2) > ECALL (11) > EBREAK (3) > misaligned store (6) > misaligned load (4).
- **OPERATING with trap:** `irq` overrides any exception.
  - Same cycle: `trap_taken_out`=1, `set_cause_out`=`set_epc_out`=`mie_clear_out`=1, `flush_out`=1, `pc_src_out`=11.
  - `cause_out` and `i_or_e_out` are valid in that cycle.
  - `instret_inc_out`=0.
  - Next state: `TRAP_TAKEN`.
- **OPERATING with MRET and no trap:** `mie_set_out`=1, `pc_src_out`=10, `flush_out`=1, `instret_inc_out`=1. Next state: `TRAP_RETURN`.
- **OPERATING otherwise:** `pc_src_out`=01, `instret_inc_out`=1. All strobes 0.
- **TRAP_TAKEN and TRAP_RETURN:** each lasts exactly one cycle with `flush_out`=1, `pc_src_out`=01 and all strobes/`instret_inc_out` 0. Both return to `OPERATING`.
  - Interrupts and exception flags are ignored in these states. A pending `irq` is taken on the first `OPERATING` cycle.
- **Strobe timing:** all strobes are single-cycle pulses. Back-to-back traps are therefore separated by at least one `TRAP_TAKEN` cycle.

Optional Feature:
- Macro: `MSRV32_TRAP_CTRL_WFI_EN`.
- **Defined:** WFI (SYSTEM, `funct3_in`=000, `funct7_in`=0001000, `rs2_addr_in`=00101) in `OPERATING` with no trap:
  - Asserts `instret_inc_out`=1 and moves to `WAIT_IRQ`.
  - `WAIT_IRQ` holds `pc_src_out`=01, `flush_out`=1 and strobes 0.
  - It exits to `OPERATING` when any enabled interrupt is pending, ignoring `mie_in`.
- **Undefined:** WFI retires as a NOP in `OPERATING`, and `WAIT_IRQ` is absent.

Test Plan:
1. Reset with `RESET_CYCLES`=2: hold `rst_in` 3 cycles, then release → `pc_src_out`=00/`flush_out`=1 for 2 cycles, then `pc_src_out`=01, `instret_inc_out`=1.
2. `illegal_instr_in`=1 and `misaligned_load_in`=1 together → same cycle `trap_taken_out`=1, `cause_out`=2, `i_or_e_out`=0, `set_epc_out`=1, `pc_src_out`=11; next cycle `flush_out`=1, strobes 0.
3. ECALL with `mie_in`=1, `mtie_in`=1, `mtip_in`=1 → `cause_out`=7, `i_or_e_out`=1; ECALL not reported.
4. `meip_in`=`msip_in`=1, enabled, but `mie_in`=0 → no trap; set `mie_in`=1 → `cause_out`=11.
5. MRET → `mie_set_out`=1, `pc_src_out`=10, `instret_inc_out`=1; then one `TRAP_RETURN` flush cycle; `mtip_in` raised during that cycle is taken the following cycle.
6. `rst_in` asserted in `TRAP_TAKEN` → next cycle reset outputs; no `set_cause_out` pulse.
